// File: rtl/pc_fetch_unit.sv
// PC stage feeding instruction memory: next-PC select, idle/run/halt control, fetch counter.
// Optional PC_BOUNDS_CHECK_EN adds a sticky bound_err that halts on out-of-range targets.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 32,
  parameter int          CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_en,
  input  logic             stall,
  input  logic             halt_req,
  input  logic             branch_taken,
  input  logic [31:0]      branch_off,
  input  logic             jump,
  input  logic [25:0]      jump_idx,
  input  logic             jr,
  input  logic [31:0]      jr_addr,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic [1:0]       state,
  output logic             halted,
  output logic             misaligned,
`ifdef PC_BOUNDS_CHECK_EN
  output logic [CNT_W-1:0] fetch_cnt,
  output logic             bound_err
`else
  output logic [CNT_W-1:0] fetch_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_HALT = 2'b10
  } state_t;

  // Reject a misaligned reset vector or an empty memory at elaboration time.
  generate
    if (RESET_PC[1:0] != 2'b00 || IMEM_WORDS < 1) begin : g_bad_param
      $error("pc_fetch_unit: RESET_PC must be word aligned and IMEM_WORDS >= 1");
    end
  endgenerate

  state_t           r_state;
  logic [31:0]      r_pc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_misaligned;

  logic [31:0]      w_pc_plus4;
  logic [31:0]      w_br_tgt;
  logic [31:0]      w_j_tgt;
  logic [31:0]      w_next_pc;
  logic             w_jr_misaligned;
  logic             w_oob;

  assign w_pc_plus4      = r_pc + 32'd4;
  assign w_br_tgt        = w_pc_plus4 + (branch_off << 2);
  assign w_j_tgt         = {w_pc_plus4[31:28], jump_idx, 2'b00};
  assign w_jr_misaligned = jr && (jr_addr[1:0] != 2'b00);

  always_comb begin
    w_next_pc = w_pc_plus4;
    if (jr)                w_next_pc = jr_addr;
    else if (jump)         w_next_pc = w_j_tgt;
    else if (branch_taken) w_next_pc = w_br_tgt;
  end

`ifdef PC_BOUNDS_CHECK_EN
  // 33-bit compare so large IMEM_WORDS cannot overflow the byte limit.
  localparam logic [32:0] LIMIT = 33'(IMEM_WORDS) * 33'd4;
  logic r_bound_err;
  assign w_oob     = ({1'b0, w_next_pc} >= LIMIT);
  assign bound_err = r_bound_err;
`else
  assign w_oob = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_cnt        <= '0;
      r_misaligned <= 1'b0;
`ifdef PC_BOUNDS_CHECK_EN
      r_bound_err  <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (halt_req)    r_state <= S_HALT;
          else if (run_en) r_state <= S_RUN;
        end
        S_RUN: begin
          if (halt_req) begin
            r_state <= S_HALT;
          end else if (w_jr_misaligned) begin
            r_misaligned <= 1'b1;
            r_state      <= S_HALT;
          end else if (stall) begin
            // Redirects presented during a stall are dropped; the source re-presents.
            r_pc <= r_pc;
          end else if (w_oob) begin
`ifdef PC_BOUNDS_CHECK_EN
            r_bound_err <= 1'b1;
`endif
            r_state <= S_HALT;
          end else begin
            r_pc <= w_next_pc;
            if (r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_HALT;
      endcase
    end
  end

  assign pc         = r_pc;
  assign pc_plus4   = w_pc_plus4;
  assign state      = r_state;
  assign halted     = (r_state == S_HALT);
  assign misaligned = r_misaligned;
  assign fetch_cnt  = r_cnt;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: sequencing, redirects, run control, saturation, wrap, bounds.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run_en, stall, halt_req, branch_taken, jump, jr;
  logic [31:0] branch_off, jr_addr;
  logic [25:0] jump_idx;
  logic [31:0] pc, pc_plus4;
  logic [1:0]  state;
  logic        halted, misaligned;
  logic [15:0] fetch_cnt;
`ifdef PC_BOUNDS_CHECK_EN
  logic        bound_err;
`endif

  logic        s_run;
  logic [31:0] s_pc, s_pc_plus4;
  logic [1:0]  s_state;
  logic        s_halted, s_misaligned;
  logic [3:0]  s_cnt;
`ifdef PC_BOUNDS_CHECK_EN
  logic        s_bound_err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_fetch_unit #(.RESET_PC(32'h0), .IMEM_WORDS(32), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .run_en(run_en), .stall(stall), .halt_req(halt_req),
    .branch_taken(branch_taken), .branch_off(branch_off), .jump(jump), .jump_idx(jump_idx),
    .jr(jr), .jr_addr(jr_addr), .pc(pc), .pc_plus4(pc_plus4), .state(state),
    .halted(halted), .misaligned(misaligned),
`ifdef PC_BOUNDS_CHECK_EN
    .fetch_cnt(fetch_cnt), .bound_err(bound_err)
`else
    .fetch_cnt(fetch_cnt)
`endif
  );

  pc_fetch_unit #(.RESET_PC(32'h0), .IMEM_WORDS(64), .CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .run_en(s_run), .stall(1'b0), .halt_req(1'b0),
    .branch_taken(1'b0), .branch_off(32'h0), .jump(1'b0), .jump_idx(26'h0),
    .jr(1'b0), .jr_addr(32'h0), .pc(s_pc), .pc_plus4(s_pc_plus4), .state(s_state),
    .halted(s_halted), .misaligned(s_misaligned),
`ifdef PC_BOUNDS_CHECK_EN
    .fetch_cnt(s_cnt), .bound_err(s_bound_err)
`else
    .fetch_cnt(s_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    run_en = 0; stall = 0; halt_req = 0; branch_taken = 0; jump = 0; jr = 0;
    branch_off = 0; jr_addr = 0; jump_idx = 0; s_run = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    #2;
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 0;
    clr_in();
    #12;
    chk("rst_pc", pc, 32'h0);
    chk("rst_state", {30'h0, state}, 32'h0);
    chk("rst_halted", {31'h0, halted}, 32'h0);
    chk("rst_misaligned", {31'h0, misaligned}, 32'h0);
    chk("rst_cnt", {16'h0, fetch_cnt}, 32'h0);
`ifdef PC_BOUNDS_CHECK_EN
    chk("rst_bound_err", {31'h0, bound_err}, 32'h0);
`endif
    chk("rst_pc_plus4", pc_plus4, 32'h4);
    @(negedge clk);
    rst_n = 1;
    #1;

    // Idle: redirects ignored, pc holds.
    jump = 1; jump_idx = 26'h10;
    tick(); chk("idle_pc0", pc, 32'h0);
    tick(); chk("idle_pc1", pc, 32'h0);
    tick(); chk("idle_pc2", pc, 32'h0);
    chk("idle_state", {30'h0, state}, 32'h0);
    run_en = 1;
    tick(); chk("start_pc", pc, 32'h0);
    chk("start_state", {30'h0, state}, 32'h1);
    clr_in();
    tick(); chk("seq_pc4", pc, 32'h4);
    tick(); chk("seq_pc8", pc, 32'h8);
    tick(); chk("seq_pc12", pc, 32'hC);
    chk("seq_cnt3", {16'h0, fetch_cnt}, 32'd3);
    tick(); chk("seq_pc16", pc, 32'h10);

    // Backward branch and jump.
    branch_taken = 1; branch_off = 32'hFFFF_FFFE;
    tick(); chk("branch_back", pc, 32'hC);
    clr_in(); jump = 1; jump_idx = 26'h8;
    tick(); chk("jump_tgt", pc, 32'h20);
    chk("jump_cnt", {16'h0, fetch_cnt}, 32'd6);

    // Redirect priority, then misaligned jr.
    clr_in(); jr = 1; jr_addr = 32'h8;
    tick(); chk("jr_pc8", pc, 32'h8);
    jump = 1; jump_idx = 26'h100; branch_taken = 1; branch_off = 32'h10; jr_addr = 32'h40;
    tick(); chk("jr_wins", pc, 32'h40);
    chk("jr_cnt", {16'h0, fetch_cnt}, 32'd8);
    clr_in(); jr = 1; jr_addr = 32'h42;
    tick(); chk("mis_flag", {31'h0, misaligned}, 32'h1);
    chk("mis_halted", {31'h0, halted}, 32'h1);
    chk("mis_pc", pc, 32'h40);
    chk("mis_cnt", {16'h0, fetch_cnt}, 32'd8);
    clr_in();
    tick(); chk("mis_sticky", {31'h0, misaligned}, 32'h1);

    // Stall, halt, run_en in halt, async reset.
    do_reset();
    chk("rst2_mis", {31'h0, misaligned}, 32'h0);
    run_en = 1; tick(); clr_in();
    tick(); chk("s_pc4", pc, 32'h4);
    stall = 1; branch_taken = 1; branch_off = 32'h4;
    tick(); chk("stall_pc_a", pc, 32'h4);
    tick(); chk("stall_pc_b", pc, 32'h4);
    chk("stall_cnt", {16'h0, fetch_cnt}, 32'd1);
    clr_in(); halt_req = 1;
    tick(); chk("halt_state", {30'h0, state}, 32'h2);
    chk("halt_pc", pc, 32'h4);
    clr_in(); run_en = 1;
    tick(); chk("halt_runen_state", {30'h0, state}, 32'h2);
    chk("halt_runen_pc", pc, 32'h4);
    chk("halt_runen_cnt", {16'h0, fetch_cnt}, 32'd1);
    clr_in();
    #2;
    rst_n = 0;
    #1;
    chk("async_pc", pc, 32'h0);
    chk("async_state", {30'h0, state}, 32'h0);
    chk("async_cnt", {16'h0, fetch_cnt}, 32'h0);
    #1;
    rst_n = 1;

`ifndef PC_BOUNDS_CHECK_EN
    // Address wrap with no bounds check.
    @(negedge clk);
    run_en = 1; tick(); clr_in();
    jr = 1; jr_addr = 32'hFFFF_FFFC;
    tick(); chk("wrap_top", pc, 32'hFFFF_FFFC);
    chk("wrap_plus4", pc_plus4, 32'h0);
    clr_in();
    tick(); chk("wrap_pc0", pc, 32'h0);
    chk("wrap_state", {30'h0, state}, 32'h1);
`else
    // Out-of-range sequential advance and jump.
    do_reset();
    run_en = 1; tick(); clr_in();
    jr = 1; jr_addr = 32'h7C;
    tick(); chk("bnd_pc7c", pc, 32'h7C);
    clr_in();
    tick(); chk("bnd_err_seq", {31'h0, bound_err}, 32'h1);
    chk("bnd_halt_seq", {31'h0, halted}, 32'h1);
    chk("bnd_pc_seq", pc, 32'h7C);
    do_reset();
    chk("bnd_rst", {31'h0, bound_err}, 32'h0);
    run_en = 1; tick(); clr_in();
    jump = 1; jump_idx = 26'h20;
    tick(); chk("bnd_err_j", {31'h0, bound_err}, 32'h1);
    chk("bnd_halt_j", {31'h0, halted}, 32'h1);
    chk("bnd_pc_j", pc, 32'h0);
    clr_in();
`endif

    // 4-bit counter saturation.
    do_reset();
    s_run = 1; tick(); s_run = 0;
    repeat (15) tick();
    chk("sat_cnt15", {28'h0, s_cnt}, 32'd15);
    repeat (5) tick();
    chk("sat_cnt20", {28'h0, s_cnt}, 32'd15);
    chk("sat_pc", s_pc, 32'h50);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter stage directly upstream of the instruction memory. Drives the byte address whose word-aligned bits select the instruction word.
- Holds the PC register and selects the next PC from four sources: sequential, branch, jump or jump-register.
- Runs a small run-control state machine with three states: idle, run and halt.
- Keeps a fetched-instruction counter for bring-up and test visibility.

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset; must be word aligned.
- IMEM_WORDS, 32: instruction memory depth in 32-bit words. Used only by the optional bounds check.
- CNT_W, 16: width of the fetch counter.

Ports:
- clk  input  1  rising-edge system clock.
- rst_n  input  1  asynchronous active-low reset.
- run_en  input  1  leaves IDLE and starts fetching.
- stall  input  1  holds the PC for this cycle.
- halt_req  input  1  stops fetching and enters HALT.
- branch_taken  input  1  selects the branch target.
- branch_off  input  32  sign-extended 16-bit immediate, in words.
- jump  input  1  selects the J-type target.
- jump_idx  input  26  J-type instr_index field.
- jr  input  1  selects the register target.
- jr_addr  input  32  register jump address (bytes).
- pc  output  32  current PC; connects to the instruction memory address.
- pc_plus4  output  32  pc + 4, used for link and branch base.
- state  output  2  00 IDLE, 01 RUN, 10 HALT.
- halted  output  1  high while in HALT.
- misaligned  output  1  sticky error flag: jr_addr[1:0] != 0.
- fetch_cnt  output  CNT_W  number of PC advances.
- bound_err  output  1  sticky bounds flag; exists only when the macro is defined.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: pc = RESET_PC, state = IDLE, halted = 0, misaligned = 0, fetch_cnt = 0, bound_err = 0.
- Reset asserted mid-operation returns the block to these values immediately, with no dependence on clk.
- pc_plus4 is combinational: pc + 4, modulo 2^32. 32'hFFFF_FFFC wraps to 32'h0000_0000 with no flag.
- Next-PC priority is jr > jump > branch_taken > sequential:
  - Branch target: pc_plus4 + (branch_off << 2), modulo 2^32. Negative offsets work through two's complement.
  - Jump target: {pc_plus4[31:28], jump_idx, 2'b00}.
  - Jump-register target: jr_addr.
- IDLE:
  - pc holds and all redirect inputs are ignored.
  - run_en = 1 at an edge moves the block to RUN; pc is not updated on that edge.
  - halt_req in IDLE moves the block to HALT.
- RUN, evaluated at each rising edge in this priority order:
  1. halt_req = 1: go to HALT; pc and fetch_cnt hold.
  2. jr = 1 with jr_addr[1:0] != 0: set misaligned, go to HALT, pc holds.
  3. stall = 1: pc and fetch_cnt hold. Any redirect presented that cycle is discarded; the source must re-present it.
  4. Otherwise: pc takes the selected next PC and fetch_cnt increments by 1.
- run_en is ignored once the block is in RUN.
- HALT:
  - Absorbing state; only rst_n leaves it.
  - pc, fetch_cnt and the flags hold.
  - halted = (state == HALT), combinational from the state register.
- fetch_cnt saturates at all-ones and does not wrap.
- Latency: the PC update is visible one cycle after the controlling inputs are sampled. No combinational path exists from the inputs to pc.

Optional Feature:
- Macro: PC_BOUNDS_CHECK_EN.
- Defined:
  - At a RUN update, a selected next PC >= IMEM_WORDS*4 does not load.
  - Instead bound_err is set (sticky), pc holds and the block goes to HALT.
  - This check has lower priority than misaligned and higher priority than a normal advance. Stall suppresses it.
- Undefined:
  - The bound_err port is absent and any 32-bit PC loads.
  - The instruction memory's index then aliases out-of-range addresses.

Test Plan:
1. Reset with run_en = 0 for 3 cycles, then run_en = 1, then 4 idle cycles -> pc sequence 0, 0, 0, 0, 4, 8, 12; fetch_cnt = 3.
2. At pc = 0x10, branch_taken = 1 with branch_off = 0xFFFF_FFFE -> pc = 0x0C. At pc = 0x0C, jump = 1 with jump_idx = 0x000_0008 -> pc = 0x20.
3. At pc = 0x08, assert jr, jump and branch_taken together with jr_addr = 0x40 -> pc = 0x40 (jr wins). Then jr_addr = 0x42 -> misaligned = 1, halted = 1, pc stays 0x40.
4. stall = 1 for 2 cycles with branch_taken = 1 -> pc and fetch_cnt unchanged. halt_req = 1 -> state = 10. run_en pulses while halted -> no change. rst_n low asynchronously, mid-cycle -> pc = 0 and state = 00 before the next edge.
5. CNT_W = 4 with 20 advances -> fetch_cnt saturates at 15. Starting at pc = 0xFFFF_FFFC with the macro undefined, one advance -> pc = 0x0000_0000.
6. With PC_BOUNDS_CHECK_EN and IMEM_WORDS = 32, at pc = 0x7C one advance -> bound_err = 1, halted = 1, pc = 0x7C. Jump to 0x80 from reset -> same response.
